// File: rtl/llc_mem_serdes_pkg.sv
// Shared types and constants for the LLC memory serdes.
// Holds word/line/address types and the serdes state encoding.
package llc_mem_serdes_pkg;

  localparam int BITS_PER_WORD  = 64;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_BITS      = 32;

  localparam int WORD_OFF_BITS  = $clog2(WORDS_PER_LINE);
  localparam int BYTE_OFF_BITS  = $clog2(BITS_PER_WORD / 8);
  localparam int LINE_ADDR_BITS =
    ADDR_BITS - WORD_OFF_BITS - BYTE_OFF_BITS;

  typedef logic [BITS_PER_WORD-1:0] word_t;
  typedef logic [BITS_PER_WORD*WORDS_PER_LINE-1:0] line_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [1:0] hprot_t;

  typedef logic [2:0] llc_mem_serdes_state_t;

  localparam llc_mem_serdes_state_t ST_IDLE       = 3'd0;
  localparam llc_mem_serdes_state_t ST_WR_BEATS   = 3'd1;
  localparam llc_mem_serdes_state_t ST_RD_ADDR    = 3'd2;
  localparam llc_mem_serdes_state_t ST_RD_COLLECT = 3'd3;
  localparam llc_mem_serdes_state_t ST_RSP_OUT    = 3'd4;
  localparam llc_mem_serdes_state_t ST_WR_ACK     = 3'd5;

  // Line-address width left after removing the in-line byte offset.
  function automatic int line_addr_w(
    input int aw,
    input int ww,
    input int wl
  );
    return aw - $clog2(ww * wl / 8);
  endfunction

endpackage

// File: rtl/llc_mem_serdes_if.sv
// Bundle of core-side and memory-side signals of the LLC memory serdes.
// LLC_MEM_SERDES_WR_ACK_EN adds the write-completion pulse.
interface llc_mem_serdes_if
  import llc_mem_serdes_pkg::*;
#(
  parameter int WORD_W = BITS_PER_WORD,
  parameter int WORDS  = WORDS_PER_LINE,
  parameter int ADDR_W = ADDR_BITS
);

  localparam int LINE_ADDR_W = line_addr_w(ADDR_W, WORD_W, WORDS);

  logic                    llc_mem_req_valid;
  logic                    llc_mem_req_ready;
  logic                    llc_mem_req_hwrite;
  logic [1:0]              llc_mem_req_hprot;
  logic [LINE_ADDR_W-1:0]  llc_mem_req_addr;
  logic [WORD_W*WORDS-1:0] llc_mem_req_line;

  logic                    llc_mem_rsp_valid;
  logic                    llc_mem_rsp_ready;
  logic [WORD_W*WORDS-1:0] llc_mem_rsp_line;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_write;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [1:0]              mem_req_hprot;
  logic [WORD_W-1:0]       mem_req_data;
  logic                    mem_req_last;

  logic                    mem_rsp_valid;
  logic                    mem_rsp_ready;
  logic [WORD_W-1:0]       mem_rsp_data;
  logic                    mem_rsp_last;

`ifdef LLC_MEM_SERDES_WR_ACK_EN
  logic                    mem_wr_ack_valid;
`endif

  logic                    serdes_err;

  modport slave (
`ifdef LLC_MEM_SERDES_WR_ACK_EN
    input  mem_wr_ack_valid,
`endif
    input  llc_mem_req_valid,
    input  llc_mem_req_hwrite,
    input  llc_mem_req_hprot,
    input  llc_mem_req_addr,
    input  llc_mem_req_line,
    input  llc_mem_rsp_ready,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_last,
    output llc_mem_req_ready,
    output llc_mem_rsp_valid,
    output llc_mem_rsp_line,
    output mem_req_valid,
    output mem_req_write,
    output mem_req_addr,
    output mem_req_hprot,
    output mem_req_data,
    output mem_req_last,
    output mem_rsp_ready,
    output serdes_err
  );

  modport master (
`ifdef LLC_MEM_SERDES_WR_ACK_EN
    output mem_wr_ack_valid,
`endif
    output llc_mem_req_valid,
    output llc_mem_req_hwrite,
    output llc_mem_req_hprot,
    output llc_mem_req_addr,
    output llc_mem_req_line,
    output llc_mem_rsp_ready,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_last,
    input  llc_mem_req_ready,
    input  llc_mem_rsp_valid,
    input  llc_mem_rsp_line,
    input  mem_req_valid,
    input  mem_req_write,
    input  mem_req_addr,
    input  mem_req_hprot,
    input  mem_req_data,
    input  mem_req_last,
    input  mem_rsp_ready,
    input  serdes_err
  );

endinterface

// File: rtl/llc_mem_serdes_linebuf.sv
// Line buffer shared by write serialisation and read assembly.
// Full-line load, single-word write by index, word and line read.
module llc_mem_serdes_linebuf #(
  parameter int WORD_W = 64,
  parameter int WORDS  = 4,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [WORD_W*WORDS-1:0] load_line,
  input  logic                    wr,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [WORD_W-1:0]       wr_word,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [WORD_W-1:0]       rd_word,
  output logic [WORD_W*WORDS-1:0] line
);

  logic [WORDS-1:0][WORD_W-1:0] mem;

  // Whole-line load wins over a single-word write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (load) begin
      mem <= load_line;
    end else if (wr) begin
      mem[wr_idx] <= wr_word;
    end
  end

  assign rd_word = mem[rd_idx];
  assign line    = mem;

endmodule

// File: rtl/llc_mem_serdes.sv
// LLC line <-> word-beat serdes between llc_core and the memory NoC.
// Define LLC_MEM_SERDES_WR_ACK_EN to wait for a write-completion pulse.
module llc_mem_serdes
  import llc_mem_serdes_pkg::*;
#(
  parameter int WORD_W = BITS_PER_WORD,
  parameter int WORDS  = WORDS_PER_LINE,
  parameter int ADDR_W = ADDR_BITS
) (
  input logic clk,
  input logic rst,
  llc_mem_serdes_if.slave bus
);

  localparam int IDX_W  = $clog2(WORDS);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int LINE_ADDR_W = line_addr_w(ADDR_W, WORD_W, WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  llc_mem_serdes_state_t state;

  logic [IDX_W-1:0]       beat_cnt;
  logic [1:0]             hprot_q;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic                   up_q;
  logic                   err_q;

  logic in_wr;
  logic in_rd;
  logic in_col;
  logic in_out;
  logic is_last;
  logic req_fire;
  logic beat_fire;
  logic col_fire;
  logic out_fire;
  logic last_bad;
  logic wr_ack;
  logic ack_stray;

  logic [WORD_W-1:0]       buf_word;
  logic [WORD_W*WORDS-1:0] buf_line;

  assign in_wr  = (state == ST_WR_BEATS);
  assign in_rd  = (state == ST_RD_ADDR);
  assign in_col = (state == ST_RD_COLLECT);
  assign in_out = (state == ST_RSP_OUT);

  assign is_last = (beat_cnt == LAST_IDX);

  assign bus.llc_mem_req_ready = up_q && (state == ST_IDLE);
  assign bus.mem_req_valid     = in_wr || in_rd;
  assign bus.mem_req_write     = in_wr;
  assign bus.mem_req_last      = in_rd || (in_wr && is_last);
  assign bus.mem_req_data      = in_wr ? buf_word : '0;
  assign bus.mem_req_hprot     = bus.mem_req_valid ? hprot_q : '0;
  assign bus.mem_req_addr      = bus.mem_req_valid
    ? {addr_q, beat_cnt, {BYTE_W{1'b0}}}
    : '0;
  assign bus.mem_rsp_ready     = in_col;
  assign bus.llc_mem_rsp_valid = in_out;
  assign bus.llc_mem_rsp_line  = in_out ? buf_line : '0;
  assign bus.serdes_err        = err_q;

  assign req_fire  = bus.llc_mem_req_valid && bus.llc_mem_req_ready;
  assign beat_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign col_fire  = in_col && bus.mem_rsp_valid;
  assign out_fire  = in_out && bus.llc_mem_rsp_ready;
  assign last_bad  = col_fire && (bus.mem_rsp_last != is_last);

`ifdef LLC_MEM_SERDES_WR_ACK_EN
  assign wr_ack    = bus.mem_wr_ack_valid;
  assign ack_stray = wr_ack && (state != ST_WR_ACK);
`else
  assign wr_ack    = 1'b0;
  assign ack_stray = 1'b0;
`endif

  llc_mem_serdes_linebuf #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .load      (req_fire && bus.llc_mem_req_hwrite),
    .load_line (bus.llc_mem_req_line),
    .wr        (col_fire),
    .wr_idx    (beat_cnt),
    .wr_word   (bus.mem_rsp_data),
    .rd_idx    (beat_cnt),
    .rd_word   (buf_word),
    .line      (buf_line)
  );

  // Hold core-side ready low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q <= 1'b0;
    end else begin
      up_q <= 1'b1;
    end
  end

  // Sticky error on misplaced last markers or stray write acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (last_bad || ack_stray) begin
      err_q <= 1'b1;
    end
  end

  // Request sequencing and beat counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      hprot_q  <= '0;
      addr_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_fire) begin
            hprot_q  <= bus.llc_mem_req_hprot;
            addr_q   <= bus.llc_mem_req_addr;
            beat_cnt <= '0;
            state    <= bus.llc_mem_req_hwrite
              ? ST_WR_BEATS
              : ST_RD_ADDR;
          end
        end
        ST_WR_BEATS: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (is_last) begin
`ifdef LLC_MEM_SERDES_WR_ACK_EN
              state <= ST_WR_ACK;
`else
              state <= ST_IDLE;
`endif
            end
          end
        end
        ST_RD_ADDR: begin
          if (beat_fire) begin
            state <= ST_RD_COLLECT;
          end
        end
        ST_RD_COLLECT: begin
          if (col_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (is_last) begin
              state <= ST_RSP_OUT;
            end
          end
        end
        ST_RSP_OUT: begin
          if (out_fire) begin
            state <= ST_IDLE;
          end
        end
        ST_WR_ACK: begin
          if (wr_ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_mem_serdes.sv
// Directed bench for llc_mem_serdes (WORD_W=64, WORDS=4, ADDR_W=32).
// Covers LLC_MEM_SERDES_WR_ACK_EN when that macro is defined.
module tb_llc_mem_serdes;
  import llc_mem_serdes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  llc_mem_serdes_if bus ();

  llc_mem_serdes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse;
`ifdef LLC_MEM_SERDES_WR_ACK_EN
    bus.mem_wr_ack_valid = 1'b1;
    tick;
    bus.mem_wr_ack_valid = 1'b0;
`endif
  endtask

  // Line write with memory always ready; a = line address.
  task automatic wr_line(
    input string     tag,
    input line_addr_t a,
    input word_t     w0,
    input word_t     w1,
    input word_t     w2,
    input word_t     w3,
    input addr_t     base
  );
    word_t w [4];
    w = '{w0, w1, w2, w3};
    chk({tag, "_rdy"}, bus.llc_mem_req_ready, 1);
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b1;
    bus.llc_mem_req_hprot  = 2'b11;
    bus.llc_mem_req_addr   = a;
    bus.llc_mem_req_line   = {w3, w2, w1, w0};
    bus.mem_req_ready      = 1'b1;
    tick;
    bus.llc_mem_req_valid  = 1'b0;
    bus.llc_mem_req_line   = '0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_vld"}, bus.mem_req_valid, 1);
      chk({tag, "_wr"}, bus.mem_req_write, 1);
      chk({tag, "_addr"}, bus.mem_req_addr, base + 32'(8 * i));
      chk({tag, "_data"}, bus.mem_req_data, w[i]);
      chk({tag, "_last"}, bus.mem_req_last, (i == 3));
      chk({tag, "_hprot"}, bus.mem_req_hprot, 2'b11);
      tick;
    end
    chk({tag, "_done"}, bus.mem_req_valid, 0);
    ack_pulse();
  endtask

  // Line read; lastv[i] is the mem_rsp_last sent with word i.
  task automatic rd_line(
    input string      tag,
    input line_addr_t a,
    input addr_t      base,
    input word_t      w0,
    input word_t      w1,
    input word_t      w2,
    input word_t      w3,
    input logic [3:0] lastv,
    input line_t      exp_line
  );
    word_t w [4];
    w = '{w0, w1, w2, w3};
    chk({tag, "_rdy"}, bus.llc_mem_req_ready, 1);
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_hprot  = 2'b01;
    bus.llc_mem_req_addr   = a;
    bus.mem_req_ready      = 1'b1;
    tick;
    bus.llc_mem_req_valid  = 1'b0;
    chk({tag, "_avld"}, bus.mem_req_valid, 1);
    chk({tag, "_awr"}, bus.mem_req_write, 0);
    chk({tag, "_aaddr"}, bus.mem_req_addr, base);
    chk({tag, "_adata"}, bus.mem_req_data, 0);
    chk({tag, "_alast"}, bus.mem_req_last, 1);
    chk({tag, "_ahprot"}, bus.mem_req_hprot, 2'b01);
    tick;
    chk({tag, "_onebeat"}, bus.mem_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_crdy"}, bus.mem_rsp_ready, 1);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = w[i];
      bus.mem_rsp_last  = lastv[i];
      tick;
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_last  = 1'b0;
    chk({tag, "_rvld"}, bus.llc_mem_rsp_valid, 1);
    chk({tag, "_line"}, bus.llc_mem_rsp_line, exp_line);
    chk({tag, "_noreq"}, bus.llc_mem_req_ready, 0);
    bus.llc_mem_rsp_ready = 1'b1;
    tick;
    bus.llc_mem_rsp_ready = 1'b0;
    chk({tag, "_rdone"}, bus.llc_mem_rsp_valid, 0);
    chk({tag, "_idle"}, bus.llc_mem_req_ready, 1);
  endtask

  word_t w3v [4];
  int    j;
  int    cyc;

  initial begin
    rst = 1'b0;
    bus.llc_mem_req_valid  = 1'b0;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_hprot  = '0;
    bus.llc_mem_req_addr   = '0;
    bus.llc_mem_req_line   = '0;
    bus.llc_mem_rsp_ready  = 1'b0;
    bus.mem_req_ready      = 1'b0;
    bus.mem_rsp_valid      = 1'b0;
    bus.mem_rsp_data       = '0;
    bus.mem_rsp_last       = 1'b0;
`ifdef LLC_MEM_SERDES_WR_ACK_EN
    bus.mem_wr_ack_valid   = 1'b0;
`endif

    // reset state
    tick;
    tick;
    chk("rst_req_rdy", bus.llc_mem_req_ready, 0);
    chk("rst_mreq_vld", bus.mem_req_valid, 0);
    chk("rst_mrsp_rdy", bus.mem_rsp_ready, 0);
    chk("rst_rsp_vld", bus.llc_mem_rsp_valid, 0);
    chk("rst_err", bus.serdes_err, 0);
    chk("rst_data", bus.mem_req_data, 0);
    chk("rst_line", bus.llc_mem_rsp_line, 0);
    rst = 1'b1;
    tick;
    chk("up_rdy", bus.llc_mem_req_ready, 1);

    // 1: write line {4,3,2,1} at line 0x100
    wr_line("t1", 27'h100, 64'd1, 64'd2, 64'd3, 64'd4,
            32'h2000);
    chk("t1_idle", bus.llc_mem_req_ready, 1);

    // 2: read line 0x101
    rd_line("t2", 27'h101, 32'h2020,
            64'hA, 64'hB, 64'hC, 64'hD, 4'b1000,
            {64'hD, 64'hC, 64'hB, 64'hA});
    chk("t2_err", bus.serdes_err, 0);

    // 3: memory ready toggling during a write
    w3v = '{64'h11, 64'h22, 64'h33, 64'h44};
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b1;
    bus.llc_mem_req_hprot  = 2'b10;
    bus.llc_mem_req_addr   = 27'h200;
    bus.llc_mem_req_line   = {w3v[3], w3v[2], w3v[1], w3v[0]};
    bus.mem_req_ready      = 1'b0;
    tick;
    bus.llc_mem_req_valid  = 1'b0;
    j   = 0;
    cyc = 0;
    while (j < 4 && cyc < 20) begin
      bus.mem_req_ready = (cyc % 2 == 1);
      chk("t3_vld", bus.mem_req_valid, 1);
      chk("t3_addr", bus.mem_req_addr, 32'h4000 + 32'(8 * j));
      chk("t3_data", bus.mem_req_data, w3v[j]);
      chk("t3_last", bus.mem_req_last, (j == 3));
      tick;
      if (cyc % 2 == 1) j++;
      cyc++;
    end
    bus.mem_req_ready = 1'b0;
    chk("t3_beats", j, 4);
    chk("t3_cycles", cyc, 8);
    chk("t3_done", bus.mem_req_valid, 0);
    ack_pulse();

    // memory data outside collection is not consumed
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hDEAD;
    chk("ign_idle", bus.mem_rsp_ready, 0);
    tick;
    chk("ign_still", bus.mem_rsp_ready, 0);
    bus.mem_rsp_valid = 1'b0;

    // 4: last marker on 2nd word
    rd_line("t4", 27'h50, 32'h0A00,
            64'h1, 64'h2, 64'h3, 64'h4, 4'b0010,
            {64'h4, 64'h3, 64'h2, 64'h1});
    chk("t4_err", bus.serdes_err, 1);

    // 5: reset during collection after 2 words
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_addr   = 27'h3;
    bus.mem_req_ready      = 1'b1;
    tick;
    bus.llc_mem_req_valid  = 1'b0;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("t5_crdy", bus.mem_rsp_ready, 1);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 64'h99;
      tick;
    end
    bus.mem_rsp_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_req_rdy", bus.llc_mem_req_ready, 0);
    chk("t5_mrsp_rdy", bus.mem_rsp_ready, 0);
    chk("t5_mreq_vld", bus.mem_req_valid, 0);
    chk("t5_rsp_vld", bus.llc_mem_rsp_valid, 0);
    chk("t5_err", bus.serdes_err, 0);
    chk("t5_line", bus.llc_mem_rsp_line, 0);
    tick;
    rst = 1'b1;
    tick;
    chk("t5_up", bus.llc_mem_req_ready, 1);
    chk("t5_noreplay", bus.mem_req_valid, 0);
    rd_line("t5r", 27'h7, 32'h00E0,
            64'h5, 64'h6, 64'h7, 64'h8, 4'b1000,
            {64'h8, 64'h7, 64'h6, 64'h5});
    chk("t5r_err", bus.serdes_err, 0);

`ifdef LLC_MEM_SERDES_WR_ACK_EN
    // 6: write waits for ack; stray ack flags an error
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b1;
    bus.llc_mem_req_addr   = 27'h9;
    bus.mem_req_ready      = 1'b1;
    tick;
    bus.llc_mem_req_valid  = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    for (int i = 0; i < 5; i++) begin
      chk("t6_wait", bus.llc_mem_req_ready, 0);
      tick;
    end
    bus.mem_wr_ack_valid = 1'b1;
    chk("t6_ackcyc", bus.llc_mem_req_ready, 0);
    tick;
    bus.mem_wr_ack_valid = 1'b0;
    chk("t6_after", bus.llc_mem_req_ready, 1);
    chk("t6_noerr", bus.serdes_err, 0);
    bus.mem_wr_ack_valid = 1'b1;
    tick;
    bus.mem_wr_ack_valid = 1'b0;
    chk("t6_stray", bus.serdes_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
